ctrl_ajuste_campos: RTL



---
 rtl/ajuste_pkg.sv | 38 +++
 rtl/detector_flanco.sv | 32 +++
 rtl/ctrl_ajuste_campos.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ajuste_pkg.sv
// Shared encodings for the field-adjust controller: FSM states and field codes.
// AUTO_REPEAT_EN adds the REPEAT state.
package ajuste_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_HOLD   = 2'd2
`ifdef AUTO_REPEAT_EN
    ,
    ST_REPEAT = 2'd3
`endif
  } estado_t;

  typedef enum logic [3:0] {
    CAMPO_NONE = 4'd0,
    CAMPO_SEG  = 4'd1,
    CAMPO_MIN  = 4'd2,
    CAMPO_HORA = 4'd3
  } campo_t;

  function automatic campo_t campo_sig(input campo_t c);
    case (c)
      CAMPO_SEG: return CAMPO_MIN;
      CAMPO_MIN: return CAMPO_HORA;
      default:   return CAMPO_SEG;
    endcase
  endfunction

  function automatic campo_t campo_ant(input campo_t c);
    case (c)
      CAMPO_SEG: return CAMPO_HORA;
      CAMPO_MIN: return CAMPO_SEG;
      default:   return CAMPO_MIN;
    endcase
  endfunction

endpackage

// File: rtl/detector_flanco.sv
// One-button input register plus rising-edge detect; both stages reset high so
// a button held across reset release never reports an edge.
module detector_flanco (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic nivel,
  output logic flanco
);

  logic cur_q, cur_d;
  logic prev_q, prev_d;

  always_comb begin
    cur_d  = btn;
    prev_d = cur_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q  <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      cur_q  <= cur_d;
      prev_q <= prev_d;
    end
  end

  assign nivel  = cur_q;
  assign flanco = cur_q & ~prev_q;

endmodule

// File: rtl/ctrl_ajuste_campos.sv
// Clock field-adjust controller: field selection, up/down strobes, inactivity
// timeout and blink. Define AUTO_REPEAT_EN to enable hold-to-repeat.
module ctrl_ajuste_campos
  import ajuste_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 50000000,
  parameter int unsigned REPEAT_CYCLES  = 25000000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000000,
  parameter int unsigned BLINK_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] en_count,
  output logic       enUP,
  output logic       enDOWN,
  output logic       modo_ajuste,
  output logic       blink
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic lvl_mode, lvl_left, lvl_right, lvl_up, lvl_down;
  logic rise_mode, rise_left, rise_right, rise_up, rise_down;

  detector_flanco u_det_mode  (.clk(clk), .reset(reset), .btn(btn_mode),  .nivel(lvl_mode),  .flanco(rise_mode));
  detector_flanco u_det_left  (.clk(clk), .reset(reset), .btn(btn_left),  .nivel(lvl_left),  .flanco(rise_left));
  detector_flanco u_det_right (.clk(clk), .reset(reset), .btn(btn_right), .nivel(lvl_right), .flanco(rise_right));
  detector_flanco u_det_up    (.clk(clk), .reset(reset), .btn(btn_up),    .nivel(lvl_up),    .flanco(rise_up));
  detector_flanco u_det_down  (.clk(clk), .reset(reset), .btn(btn_down),  .nivel(lvl_down),  .flanco(rise_down));

  estado_t       state_q, state_d;
  campo_t        campo_q, campo_d;
  logic          dir_up_q, dir_up_d;
  logic          str_up_q, str_up_d;
  logic          str_dn_q, str_dn_d;
  logic          en_up_q, en_up_d;
  logic          en_dn_q, en_dn_d;
  logic          blink_q, blink_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [TW-1:0] inact_q, inact_d;
  logic          dir_held;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
`endif

  assign dir_held = dir_up_q ? lvl_up : lvl_down;

  always_comb begin
    state_d  = state_q;
    campo_d  = campo_q;
    dir_up_d = dir_up_q;
    str_up_d = 1'b0;
    str_dn_d = 1'b0;
`ifdef AUTO_REPEAT_EN
    rep_cnt_d = rep_cnt_q;
`endif

    if (lvl_mode | lvl_left | lvl_right | lvl_up | lvl_down)
      inact_d = '0;
    else if (inact_q == TW'(TIMEOUT_CYCLES))
      inact_d = inact_q;
    else
      inact_d = inact_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        campo_d = CAMPO_NONE;
        if (rise_mode) begin
          state_d = ST_SELECT;
          campo_d = CAMPO_SEG;
        end
      end
      ST_SELECT: begin
`ifdef AUTO_REPEAT_EN
        rep_cnt_d = '0;
`endif
        if (rise_mode) begin
          state_d = ST_IDLE;
          campo_d = CAMPO_NONE;
        end else if (rise_up && !lvl_down) begin
          state_d  = ST_HOLD;
          dir_up_d = 1'b1;
          str_up_d = 1'b1;
        end else if (rise_down && !lvl_up) begin
          state_d  = ST_HOLD;
          dir_up_d = 1'b0;
          str_dn_d = 1'b1;
        end else if (rise_right) begin
          campo_d = campo_sig(campo_q);
        end else if (rise_left) begin
          campo_d = campo_ant(campo_q);
        end
      end
      ST_HOLD: begin
        if ((lvl_up && lvl_down) || !dir_held) begin
          state_d = ST_SELECT;
        end
`ifdef AUTO_REPEAT_EN
        else if (rep_cnt_q == RW'(HOLD_CYCLES - 1)) begin
          state_d   = ST_REPEAT;
          rep_cnt_d = '0;
          str_up_d  = dir_up_q;
          str_dn_d  = !dir_up_q;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
`endif
      end
`ifdef AUTO_REPEAT_EN
      ST_REPEAT: begin
        if ((lvl_up && lvl_down) || !dir_held) begin
          state_d = ST_SELECT;
        end else if (rep_cnt_q == RW'(REPEAT_CYCLES - 1)) begin
          rep_cnt_d = '0;
          str_up_d  = dir_up_q;
          str_dn_d  = !dir_up_q;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        campo_d = CAMPO_NONE;
      end
    endcase

    if (state_q != ST_IDLE && inact_q == TW'(TIMEOUT_CYCLES)) begin
      state_d  = ST_IDLE;
      campo_d  = CAMPO_NONE;
      str_up_d = 1'b0;
      str_dn_d = 1'b0;
    end

    // Decision and output stages give the two-edge strobe latency from first sample.
    en_up_d = str_up_q;
    en_dn_d = str_dn_q;

    if (state_d == ST_IDLE) begin
      blink_d = 1'b0;
      bcnt_d  = '0;
    end else if (state_d == ST_SELECT && state_q != ST_SELECT) begin
      blink_d = 1'b1;
      bcnt_d  = '0;
    end else if (bcnt_q == BW'(BLINK_CYCLES - 1)) begin
      blink_d = ~blink_q;
      bcnt_d  = '0;
    end else begin
      blink_d = blink_q;
      bcnt_d  = bcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      campo_q  <= CAMPO_NONE;
      dir_up_q <= 1'b0;
      str_up_q <= 1'b0;
      str_dn_q <= 1'b0;
      en_up_q  <= 1'b0;
      en_dn_q  <= 1'b0;
      blink_q  <= 1'b0;
      bcnt_q   <= '0;
      inact_q  <= '0;
`ifdef AUTO_REPEAT_EN
      rep_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      campo_q  <= campo_d;
      dir_up_q <= dir_up_d;
      str_up_q <= str_up_d;
      str_dn_q <= str_dn_d;
      en_up_q  <= en_up_d;
      en_dn_q  <= en_dn_d;
      blink_q  <= blink_d;
      bcnt_q   <= bcnt_d;
      inact_q  <= inact_d;
`ifdef AUTO_REPEAT_EN
      rep_cnt_q <= rep_cnt_d;
`endif
    end
  end

  assign en_count    = campo_q;
  assign enUP        = en_up_q;
  assign enDOWN      = en_dn_q;
  assign modo_ajuste = (state_q != ST_IDLE);
  assign blink       = blink_q;

endmodule
